fetch: RTL and testbench

Instruction fetch stage of the RV32I_Zicsr pipeline, directly upstream of decode. Maintains the program counter, issues one-outstanding-request reads to instruction memory over a req/ack handshake, and presents a registered instruction/PC pair to decode. Handles pipeline stall (hold) and flush/redirect (branch, jump, trap), including redirects that arrive while a memory request is in flight.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if.sv | 11 +
 rtl/fetch.sv | 116 +++++++++++
 tb/tb_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset defaults, FSM encoding and PC helper for the fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory read channel, one outstanding request, req held until ack.
interface fetch_if;
    import fetch_pkg::*;
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] data;

    modport master (output req, addr, input ack, data);
    modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/fetch.sv
// fetch: RV32I fetch stage; keeps the PC, reads imem one request at a time and
// presents a registered inst/pc pair to decode, with stall skid buffer and redirect.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_redirect_pc,
    fetch_if.master         imem,
    output logic [XLEN-1:0] or_inst,
    output logic [XLEN-1:0] or_pc,
    output logic            or_valid
);
    fetch_state_t    r_state, w_state;
    logic [XLEN-1:0] r_fetch_pc, w_fetch_pc;
    logic [XLEN-1:0] r_redir_pc, w_redir_pc;
    logic [XLEN-1:0] r_hold_inst, w_hold_inst;
    logic [XLEN-1:0] r_hold_pc, w_hold_pc;
    logic [XLEN-1:0] w_inst, w_pc, w_target;
    logic            w_valid;

    assign imem.req  = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem.addr = r_fetch_pc;
    assign w_target  = align_pc(i_redirect_pc);

    always_comb begin
        w_state     = r_state;
        w_fetch_pc  = r_fetch_pc;
        w_redir_pc  = r_redir_pc;
        w_hold_inst = r_hold_inst;
        w_hold_pc   = r_hold_pc;
        w_inst      = or_inst;
        w_pc        = or_pc;
        w_valid     = or_valid;
        case (r_state)
            S_IDLE: w_state = S_REQ;
            S_REQ: begin
                if (i_flush) begin
                    w_valid = 1'b0;
                    w_inst  = NOP_INST;
                    if (imem.ack) begin
                        w_fetch_pc = w_target;
                    end else begin
                        w_redir_pc = w_target;
                        w_state    = S_DRAIN;
                    end
                end else if (imem.ack) begin
                    w_fetch_pc = r_fetch_pc + XLEN'(4);
                    if (i_stall) begin
                        w_hold_inst = imem.data;
                        w_hold_pc   = r_fetch_pc;
                        w_state     = S_HOLD;
                    end else begin
                        w_inst  = imem.data;
                        w_pc    = r_fetch_pc;
                        w_valid = 1'b1;
                    end
                end else if (!i_stall) begin
                    // decode consumed the last instruction and nothing new arrived: bubble
                    w_valid = 1'b0;
                    w_inst  = NOP_INST;
                end
            end
            S_HOLD: begin
                if (i_flush) begin
                    w_valid    = 1'b0;
                    w_inst     = NOP_INST;
                    w_fetch_pc = w_target;
                    w_state    = S_REQ;
                end else if (!i_stall) begin
                    w_inst  = r_hold_inst;
                    w_pc    = r_hold_pc;
                    w_valid = 1'b1;
                    w_state = S_REQ;
                end
            end
            S_DRAIN: begin
                // the in-flight read must finish before the redirect target is requested
                if (imem.ack) begin
                    w_fetch_pc = i_flush ? w_target : r_redir_pc;
                    w_state    = S_REQ;
                end else if (i_flush) begin
                    w_redir_pc = w_target;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_redir_pc  <= '0;
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
            or_inst     <= NOP_INST;
            or_pc       <= '0;
            or_valid    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_fetch_pc  <= w_fetch_pc;
            r_redir_pc  <= w_redir_pc;
            r_hold_inst <= w_hold_inst;
            r_hold_pc   <= w_hold_pc;
            or_inst     <= w_inst;
            or_pc       <= w_pc;
            or_valid    <= w_valid;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed scenarios plus random stall/flush/latency traffic, checked against
// a program-order scoreboard of the instruction stream decode should accept.
module tb_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] or_inst, or_pc;
    logic        or_valid;

    fetch_if imem_bus ();

    fetch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect_pc (rpc),
        .imem          (imem_bus),
        .or_inst       (or_inst),
        .or_pc         (or_pc),
        .or_valid      (or_valid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_accept = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          mem_wait = 0;
    int          idle_run = 0;
    logic        mem_pend = 1'b0;
    logic        late_ack = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_pc = '0;
    logic [31:0] sv_inst, sv_pc;
    logic        sv_valid;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive inputs, answer imem, score the visible outputs, advance
    task automatic step(input logic s, input logic f, input logic [31:0] r);
        stall = s;
        flush = f;
        rpc   = r;
        if (mem_pend) begin
            check("req_held", {31'b0, imem_bus.req}, 32'd1);
            check("addr_stable", imem_bus.addr, prev_addr);
        end
        if (imem_bus.req) check("addr_align", {30'b0, imem_bus.addr[1:0]}, 32'd0);
        if (late_ack) begin
            imem_bus.ack  = 1'b1;
            imem_bus.data = 32'hDEAD_BEEF;
            mem_pend      = 1'b0;
        end else if (imem_bus.req) begin
            if (!mem_pend) begin
                mem_pend = 1'b1;
                mem_wait = $urandom_range(lat_max, lat_min);
            end
            if (mem_wait == 0) begin
                imem_bus.ack  = 1'b1;
                imem_bus.data = memf(imem_bus.addr);
                mem_pend      = 1'b0;
            end else begin
                imem_bus.ack  = 1'b0;
                imem_bus.data = 32'hBAD0_BAD0;
                mem_wait--;
            end
        end else begin
            imem_bus.ack  = 1'b0;
            imem_bus.data = 32'hBAD0_BAD0;
            mem_pend      = 1'b0;
        end
        prev_addr = imem_bus.addr;
        if (hold_prev) begin
            check("stall_valid", {31'b0, or_valid}, {31'b0, sv_valid});
            check("stall_inst", or_inst, sv_inst);
            check("stall_pc", or_pc, sv_pc);
        end
        if (or_valid) begin
            check("sb_pc", or_pc, exp_pc);
            check("sb_inst", or_inst, memf(exp_pc));
        end else begin
            check("bubble_nop", or_inst, NOP);
        end
        idle_run = (rst_n && !s && !f && !or_valid) ? idle_run + 1 : 0;
        check("liveness", {31'b0, idle_run > 10}, 32'd0);
        if (!rst_n) begin
            exp_pc   = 32'h0;
            mem_pend = 1'b0;
        end else if (f) begin
            exp_pc = r & 32'hFFFF_FFFC;
        end else if (or_valid && !s) begin
            exp_pc = exp_pc + 32'd4;
            n_accept++;
        end
        hold_prev = s && !f && rst_n;
        sv_inst   = or_inst;
        sv_pc     = or_pc;
        sv_valid  = or_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, or_valid}, {31'b0, v});
        if (v) begin
            check({tag, "_pc"}, or_pc, pc);
            check({tag, "_inst"}, or_inst, memf(pc));
        end else begin
            check({tag, "_inst"}, or_inst, NOP);
        end
    endtask

    task automatic expect_req(input string tag, input logic q, input logic [31:0] a);
        check({tag, "_req"}, {31'b0, imem_bus.req}, {31'b0, q});
        if (q) check({tag, "_addr"}, imem_bus.addr, a);
    endtask

    initial begin
        int base;
        imem_bus.ack  = 1'b0;
        imem_bus.data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, or_valid}, 32'd0);
        check("rst_inst", or_inst, NOP);
        check("rst_pc", or_pc, 32'd0);
        expect_req("rst", 1'b0, 32'd0);

        // zero-wait stream from reset
        rst_n = 1'b1;
        step(0, 0, 0);
        expect_req("first_req", 1'b1, 32'h0);
        expect_out("first_req", 1'b0, 32'h0);
        step(0, 0, 0);
        expect_out("first_valid", 1'b1, 32'h0);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 0);
            expect_out("stream", 1'b1, 32'(i * 4));
        end

        // stall on the ack of 0x10
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            expect_out("stall_hold", 1'b1, 32'h0C);
            expect_req("stall_hold", 1'b0, 32'h0);
        end
        step(0, 0, 0);
        expect_out("unstall_a", 1'b1, 32'h10);
        step(0, 0, 0);
        expect_out("unstall_b", 1'b1, 32'h14);

        // 3-wait memory
        lat_min = 3; lat_max = 3;
        step(0, 0, 0);
        expect_out("wait3_bubble", 1'b0, 32'h0);
        expect_req("wait3", 1'b1, 32'h18);
        repeat (3) step(0, 0, 0);
        expect_out("wait3_a", 1'b1, 32'h18);
        repeat (4) step(0, 0, 0);
        expect_out("wait3_b", 1'b1, 32'h1C);

        // flush with ack, then flush while a 2-wait read of 0x40 is in flight
        lat_min = 0; lat_max = 0;
        step(0, 1, 32'h40);
        expect_out("flush_ack", 1'b0, 32'h0);
        expect_req("flush_ack", 1'b1, 32'h40);
        lat_min = 2; lat_max = 2;
        step(0, 1, 32'h200);
        expect_req("drain_a", 1'b1, 32'h40);
        expect_out("drain_a", 1'b0, 32'h0);
        step(0, 0, 0);
        expect_req("drain_b", 1'b1, 32'h40);
        step(0, 0, 0);
        expect_req("drain_done", 1'b1, 32'h200);
        expect_out("drain_done", 1'b0, 32'h0);
        repeat (2) step(0, 0, 0);
        expect_out("redir_wait", 1'b0, 32'h0);
        step(0, 0, 0);
        expect_out("redir_200", 1'b1, 32'h200);

        // second flush during DRAIN wins
        step(0, 1, 32'h400);
        step(0, 1, 32'h300);
        step(0, 0, 0);
        expect_req("drain_latest", 1'b1, 32'h300);
        lat_min = 0; lat_max = 0;
        step(0, 0, 0);
        expect_out("redir_300", 1'b1, 32'h300);

        // flush coincident with the draining ack uses the new target
        lat_min = 1; lat_max = 1;
        step(0, 1, 32'h500);
        step(0, 1, 32'h600);
        expect_req("drain_ack_flush", 1'b1, 32'h600);
        lat_min = 0; lat_max = 0;
        step(0, 0, 0);
        expect_out("redir_600", 1'b1, 32'h600);

        // flush + stall together in HOLD, unaligned target
        step(1, 0, 0);
        expect_out("hold_enter", 1'b1, 32'h600);
        expect_req("hold_enter", 1'b0, 32'h0);
        step(1, 1, 32'h103);
        expect_out("hold_flush", 1'b0, 32'h0);
        expect_req("hold_flush", 1'b1, 32'h100);
        step(0, 0, 0);
        expect_out("redir_100", 1'b1, 32'h100);

        // PC wraps at the top of the address space
        step(0, 1, 32'hFFFF_FFFE);
        step(0, 0, 0);
        expect_out("wrap_top", 1'b1, 32'hFFFF_FFFC);
        step(0, 0, 0);
        expect_out("wrap_zero", 1'b1, 32'h0);

        // reset mid 3-wait request, late ack lands in IDLE
        lat_min = 3; lat_max = 3;
        repeat (2) step(0, 0, 0);
        rst_n = 1'b0;
        step(0, 0, 0);
        expect_out("mid_rst", 1'b0, 32'h0);
        check("mid_rst_pc", or_pc, 32'h0);
        expect_req("mid_rst", 1'b0, 32'h0);
        rst_n = 1'b1;
        late_ack = 1'b1;
        step(0, 0, 0);
        late_ack = 1'b0;
        expect_req("late_ack", 1'b1, 32'h0);
        expect_out("late_ack", 1'b0, 32'h0);
        repeat (4) step(0, 0, 0);
        expect_out("restart", 1'b1, 32'h0);

        // random traffic against the scoreboard
        lat_min = 0; lat_max = 3;
        base = n_accept;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6, $urandom);
        end
        rst_n = 1'b1;
        check("progress", {31'b0, (n_accept - base) >= 200}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
